// File: rtl/demux2_buf.sv
// Buffered 1-to-2 demultiplexer: input words tagged by s are steered into two independent FIFOs.
// Optional alternation checker compiled in when DEMUX2_ALT_CHECK_EN is defined.
module demux2_buf #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             s,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_valid,
  output logic             y1_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  output logic             seq_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  ptr_t             wr_ptr_q [2];
  ptr_t             wr_ptr_d [2];
  ptr_t             rd_ptr_q [2];
  ptr_t             rd_ptr_d [2];
  cnt_t             cnt_q [2];
  cnt_t             cnt_d [2];
  logic [WIDTH-1:0] y_q [2];
  logic [WIDTH-1:0] y_d [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       y_ready;
  logic             accept;

  assign y_ready = {y1_ready, y0_ready};
  assign a_ready = (cnt_q[s] != CntW'(DEPTH));
  assign accept  = a_valid && a_ready;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      push[ch]     = accept && (int'(s) == ch);
      pop[ch]      = (cnt_q[ch] != '0) && y_ready[ch];
      mem_d[ch]    = mem_q[ch];
      wr_ptr_d[ch] = push[ch] ? wr_ptr_q[ch] + ptr_t'(1) : wr_ptr_q[ch];
      rd_ptr_d[ch] = pop[ch]  ? rd_ptr_q[ch] + ptr_t'(1) : rd_ptr_q[ch];
      unique case ({push[ch], pop[ch]})
        2'b10:   cnt_d[ch] = cnt_q[ch] + cnt_t'(1);
        2'b01:   cnt_d[ch] = cnt_q[ch] - cnt_t'(1);
        default: cnt_d[ch] = cnt_q[ch];
      endcase
      if (push[ch]) mem_d[ch][wr_ptr_q[ch]] = a;
      // Output register tracks the next head; the pushed word is the head when the slot
      // being written is the one the read pointer lands on (FIFO empty after this edge's pop).
      y_d[ch] = y_q[ch];
      if (cnt_d[ch] != '0) begin
        y_d[ch] = (push[ch] && (wr_ptr_q[ch] == rd_ptr_d[ch])) ? a : mem_q[ch][rd_ptr_d[ch]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[ch][i] <= '0;
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        cnt_q[ch]    <= '0;
        y_q[ch]      <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        mem_q[ch]    <= mem_d[ch];
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
        y_q[ch]      <= y_d[ch];
      end
    end
  end

  assign y0       = y_q[0];
  assign y1       = y_q[1];
  assign y0_valid = (cnt_q[0] != '0);
  assign y1_valid = (cnt_q[1] != '0);

`ifdef DEMUX2_ALT_CHECK_EN
  typedef enum logic {StExp0, StExp1} chk_state_e;

  chk_state_e state_q, state_d;
  logic       seq_err_q, seq_err_d;
  logic       exp_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StExp0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seq_err_d = seq_err_q;
    if (accept) begin
      // Match toggles and mismatch resyncs; both end up expecting the channel opposite to s.
      state_d = s ? StExp0 : StExp1;
      if (s != exp_ch) seq_err_d = 1'b1;
    end
  end

  always_comb begin
    exp_ch  = (state_q == StExp1);
    seq_err = seq_err_q;
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux2_buf.sv
// Directed self-checking bench for demux2_buf (WIDTH=4, DEPTH=2).
module tb_demux2_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic       s;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] y0, y1;
  logic       y0_valid, y1_valid;
  logic       y0_ready, y1_ready;
  logic       seq_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DEMUX2_ALT_CHECK_EN
  localparam logic AltEn = 1'b1;
`else
  localparam logic AltEn = 1'b0;
`endif

  demux2_buf #(.WIDTH(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .s        (s),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .y0       (y0),
    .y1       (y1),
    .y0_valid (y0_valid),
    .y1_valid (y1_valid),
    .y0_ready (y0_ready),
    .y1_ready (y1_ready),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic sel, input logic v);
    a       = d;
    s       = sel;
    a_valid = v;
  endtask

  initial begin
    rst_n = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    drive(4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset then idle
    check("rst_y0_valid", y0_valid, 0);
    check("rst_y1_valid", y1_valid, 0);
    check("rst_y0", y0, 0);
    check("rst_y1", y1, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_seq_err", seq_err, 0);

    // Basic routing, popped as soon as presented
    y0_ready = 1'b1; y1_ready = 1'b1;
    drive(4'h3, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_y0_valid", y0_valid, 1);
    check("t2_y0", y0, 4'h3);
    drive(4'hA, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_y0_popped", y0_valid, 0);
    check("t2_y0_hold", y0, 4'h3);
    check("t2_y1_valid", y1_valid, 1);
    check("t2_y1", y1, 4'hA);
    drive(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_y1_popped", y1_valid, 0);
    check("t2_y1_hold", y1, 4'hA);
    check("t2_seq_err", seq_err, 0);

    // Alternation sequence s = 0, 1, 1
    drive(4'h5, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_y0", y0, 4'h5);
    check("t5_err_a", seq_err, 0);
    drive(4'h6, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_y1", y1, 4'h6);
    check("t5_y0_popped", y0_valid, 0);
    check("t5_err_b", seq_err, 0);
    drive(4'h9, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_y1_pushpop", y1, 4'h9);
    check("t5_y1_valid", y1_valid, 1);
    check("t5_err_c", seq_err, AltEn);
    y1_ready = 1'b0; y0_ready = 1'b0;
    drive(4'h4, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_err_sticky", seq_err, AltEn);
    check("t5_y0_mid", y0, 4'h4);
    check("t5_y1_mid", y1, 4'h9);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_y0_valid", y0_valid, 0);
    check("arst_y1_valid", y1_valid, 0);
    check("arst_y0", y0, 0);
    check("arst_y1", y1, 0);
    check("arst_a_ready", a_ready, 1);
    check("arst_seq_err", seq_err, 0);
    drive(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill channel 0 with consumer stalled
    drive(4'h1, 1'b0, 1'b1);
    #1 check("t3_ready_1", a_ready, 1);
    @(negedge clk);
    check("t3_y0_first", y0, 4'h1);
    drive(4'h2, 1'b0, 1'b1);
    @(negedge clk);
    drive(4'h3, 1'b0, 1'b1);
    #1 check("t3_full_ready", a_ready, 0);
    @(negedge clk);
    check("t3_full_hold", y0, 4'h1);
    check("t3_full_ready2", a_ready, 0);

    // Channel 1 still open while channel 0 is full
    drive(4'h7, 1'b1, 1'b1);
    #1 check("t4_ready", a_ready, 1);
    @(negedge clk);
    check("t4_y1", y1, 4'h7);
    check("t4_y1_valid", y1_valid, 1);
    check("t4_y0_unaff", y0, 4'h1);
    check("t4_y0_valid", y0_valid, 1);

    // Drain channel 0; the stalled word enters only after a pop frees a slot
    drive(4'h3, 1'b0, 1'b1);
    y0_ready = 1'b1; y1_ready = 1'b1;
    #1 check("t3_no_passthru", a_ready, 0);
    @(negedge clk);
    check("t3_pop1", y0, 4'h2);
    check("t3_ready_after", a_ready, 1);
    check("t4_y1_drained", y1_valid, 0);
    @(negedge clk);
    check("t3_pop2", y0, 4'h3);
    check("t3_pop2_valid", y0_valid, 1);
    drive(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_empty", y0_valid, 0);
    check("t3_hold", y0, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux2_buf.md
# demux2_buf

Buffered 1-to-2 demultiplexer: the receive-side counterpart of the team's 2:1 word mux. A single WIDTH-bit input stream, tagged per word with a select bit `s`, is steered into one of two per-channel FIFOs; each channel drains independently through its own valid/ready handshake. It sits downstream of a 2:1 mux link and restores the two original channels, absorbing short stalls on either side.

## Interface
- `WIDTH`, 4, data word width in bits.
- `DEPTH`, 2, entries per channel FIFO; power of two, at least 2.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a`  input  WIDTH  input data word.
- `s`  input  1  channel tag for `a`: 0 routes to channel 0, 1 routes to channel 1.
- `a_valid`  input  1  `a` and `s` are valid this cycle.
- `a_ready`  output  1  the FIFO selected by `s` is not full.
- `y0`, `y1`  output  WIDTH  head word of channel 0 / channel 1 FIFO.
- `y0_valid`, `y1_valid`  output  1  the channel FIFO is non-empty.
- `y0_ready`, `y1_ready`  input  1  the downstream consumer takes the head word.
- `seq_err`  output  1  sticky alternation-violation flag; tied 0 unless `DEMUX2_ALT_CHECK_EN` is defined.

## Operation
- Accept: `a_valid && a_ready` at a rising edge writes `a` into FIFO[`s`]. `a_ready` is combinational from `s` and FIFO[`s`] full; it does not depend on `a_valid`.
- Drain: `yN_valid && yN_ready` at a rising edge pops FIFO N. `yN` is the head entry. When `yN_valid` = 0, `yN` holds its last value.
- Each FIFO has its own write pointer, read pointer, and occupancy count (0..DEPTH). Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full FIFO: `a_ready` = 0 while `s` selects it, even if a pop occurs in the same cycle. There is no pass-through when full.
- Empty FIFO: a write is visible on `yN` / `yN_valid` the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop on the same non-full, non-empty FIFO: the count is unchanged and both pointers advance.
- Simultaneous accept into one channel and pop from the other: the two channels are fully independent.
- A word is never dropped, duplicated or reordered within a channel. Words of different channels have no relative ordering at the outputs.
- Reset, including mid-transfer:
  - Both FIFOs are emptied.
  - `y0_valid` = `y1_valid` = 0.
  - `y0` = `y1` = 0, and storage is cleared to 0.
  - `a_ready` = 1.
  - `seq_err` = 0.
  - The checker FSM goes to EXP0.
  - Contents in flight at reset are lost.

## Timing
- Input-to-output latency is 1 cycle: a word accepted at edge k is presented with `yN_valid` = 1 after edge k.
- Throughput is one accept per cycle on the input, plus one pop per cycle on each output.
- `a_ready` is combinational from `s` and registered state. `yN` and `yN_valid` come from registered state only.
- Asynchronous reset takes effect immediately. Deassertion is released synchronously by the surrounding reset synchronizer; the block adds none.

## Configuration
- Macro: `DEMUX2_ALT_CHECK_EN`.
- Defined: an alternation checker FSM with states EXP0 and EXP1 is compiled in. It reset to EXP0.
  - On each accepted word with `s` matching the expected channel, the FSM toggles.
  - On an accepted word with `s` not matching the expected channel, `seq_err` sets at that edge and stays 1 until reset. The FSM resynchronises to expect the channel opposite to the received `s`.
  - The word is still accepted and routed normally.
  - Cycles with no accept do not change the state.
- Not defined: no FSM is built and `seq_err` is constant 0. Data path behaviour is identical.

## Test plan
- Reset then idle: `y0_valid` = `y1_valid` = 0, `y0` = `y1` = 0, `a_ready` = 1, `seq_err` = 0.
- Push 4'h3 with `s`=0, then 4'hA with `s`=1, with both ready = 1: `y0` = 3 / `y0_valid` = 1 one cycle after the first accept, and `y1` = A one cycle after the second. Each is popped the cycle it appears.
- Hold `y0_ready` = 0 and push 4'h1, 4'h2, 4'h3 to channel 0 (DEPTH = 2): the first two are accepted, and `a_ready` = 0 for the third. Pulse `y0_ready` with 4'h3 still presented: `y0` reads 1 then 2, 4'h3 is accepted only after the pop, and no data is lost.
- Channel 0 full and stalled, push 4'h7 with `s`=1: accepted (`a_ready` = 1), and `y1` = 7 next cycle. Channel 0 is unaffected.
- With `DEMUX2_ALT_CHECK_EN`, push `s` = 0, 1, 1: `seq_err` rises after the third accept and stays 1. Assert `rst_n` = 0 mid-stream: all valids and `seq_err` clear immediately.
- Without the macro, the same `s` sequence leaves `seq_err` = 0, with identical data outputs.
